// File: rtl/arith_responder.sv
// Shared Q-format arithmetic unit: two add lanes, pipelined multiply, iterative
// exponent (square-and-multiply) and restoring divide, each with a done pulse.
module arith_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int EXP_BITS   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0][DATA_WIDTH-1:0] add_a,
  input  logic [1:0][DATA_WIDTH-1:0] add_b,
  input  logic [1:0]                 add_start,
  output logic [1:0][DATA_WIDTH-1:0] add_result,
  output logic [1:0]                 add_done,
  input  logic [DATA_WIDTH-1:0]      mult_a,
  input  logic [DATA_WIDTH-1:0]      mult_b,
  input  logic                       mult_start,
  output logic [DATA_WIDTH-1:0]      mult_result,
  output logic                       mult_done,
  input  logic [DATA_WIDTH-1:0]      exponent_a,
  input  logic [DATA_WIDTH-1:0]      exponent_b,
  input  logic                       exponent_start,
  output logic [DATA_WIDTH-1:0]      exponent_result,
  output logic                       exponent_done,
  output logic                       exponent_busy,
  input  logic [DATA_WIDTH-1:0]      divide_a,
  input  logic [DATA_WIDTH-1:0]      divide_b,
  input  logic                       divide_start,
  output logic [DATA_WIDTH-1:0]      divide_result,
  output logic                       divide_done,
  output logic                       divide_busy,
  output logic                       divide_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int DW = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(DW + 1);
  localparam int EW = $clog2(EXP_BITS + 1);
  localparam logic signed [2*W-1:0] SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC_BITS;

  function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] x);
    return {{W{x[W-1]}}, x};
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [2*W-1:0] x);
    if (x > SMAX) return SMAX[W-1:0];
    else if (x < SMIN) return SMIN[W-1:0];
    else return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = sx(a) * sx(b);
    return sat(p >>> FRAC_BITS);
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  // add lanes
  always_ff @(posedge clock) begin
    if (!reset) begin
      add_result <= '0;
      add_done   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        add_done[i] <= add_start[i];
        if (add_start[i]) add_result[i] <= sat(sx(add_a[i]) + sx(add_b[i]));
      end
    end
  end

  // multiply: raw product in stage 1, shift and clamp in stage 2
  logic signed [2*W-1:0] mult_prod;
  logic                  mult_vld;

  always_ff @(posedge clock) begin
    if (!reset) begin
      mult_prod   <= '0;
      mult_vld    <= 1'b0;
      mult_result <= '0;
      mult_done   <= 1'b0;
    end else begin
      mult_vld  <= mult_start;
      mult_done <= mult_vld;
      if (mult_start) mult_prod <= sx(mult_a) * sx(mult_b);
      if (mult_vld) mult_result <= sat(mult_prod >>> FRAC_BITS);
    end
  end

  // exponent
  typedef enum logic [1:0] {EXP_IDLE = 2'd0, EXP_RUN = 2'd1, EXP_DONE = 2'd2} exp_state_t;
  exp_state_t           exp_state, exp_next;
  logic [W-1:0]         exp_base, exp_acc, exp_acc_nx, exp_base_nx;
  logic [EXP_BITS-1:0]  exp_pwr;
  logic [EW-1:0]        exp_cnt;

  always_ff @(posedge clock) begin
    if (!reset) exp_state <= EXP_IDLE;
    else        exp_state <= exp_next;
  end

  always_comb begin
    exp_next    = exp_state;
    exp_acc_nx  = exp_pwr[0] ? fmul(exp_acc, exp_base) : exp_acc;
    exp_base_nx = fmul(exp_base, exp_base);
    case (exp_state)
      EXP_IDLE: if (exponent_start) exp_next = EXP_RUN;
      EXP_RUN:  if (exp_cnt == '0) exp_next = EXP_DONE;
      EXP_DONE: exp_next = EXP_IDLE;
      default:  exp_next = EXP_IDLE;
    endcase
  end

  assign exponent_busy = (exp_state != EXP_IDLE);
  assign exponent_done = (exp_state == EXP_DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      exp_base        <= '0;
      exp_acc         <= '0;
      exp_pwr         <= '0;
      exp_cnt         <= '0;
      exponent_result <= '0;
    end else if (exp_state == EXP_IDLE && exponent_start) begin
      exp_base <= exponent_a;
      exp_pwr  <= exponent_b[EXP_BITS-1:0];
      exp_acc  <= ONE;
      exp_cnt  <= EW'(EXP_BITS - 1);
    end else if (exp_state == EXP_RUN) begin
      exp_acc  <= exp_acc_nx;
      exp_base <= exp_base_nx;
      exp_pwr  <= exp_pwr >> 1;
      exp_cnt  <= exp_cnt - EW'(1);
      if (exp_cnt == '0) exponent_result <= exp_acc_nx;
    end
  end

  // divide: magnitudes through a restoring divider, sign applied at the end
  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_FIX = 2'd2, DIV_DONE = 2'd3} div_state_t;
  div_state_t            div_state, div_next;
  logic [DW-1:0]         div_dq;
  logic [W-1:0]          div_rem, div_dvs, div_diff;
  logic [W:0]            div_sh;
  logic                  div_ge, div_neg, div_sa;
  logic [CW-1:0]         div_cnt;
  logic signed [2*W-1:0] div_qx;

  always_ff @(posedge clock) begin
    if (!reset) div_state <= DIV_IDLE;
    else        div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    div_sh   = {div_rem, div_dq[DW-1]};
    div_ge   = (div_sh >= {1'b0, div_dvs});
    div_diff = div_sh[W-1:0] - div_dvs;
    div_qx   = {{(2*W-DW){1'b0}}, div_dq};
    case (div_state)
      DIV_IDLE: if (divide_start) div_next = (divide_b == '0) ? DIV_FIX : DIV_RUN;
      DIV_RUN:  if (div_cnt == '0) div_next = DIV_FIX;
      DIV_FIX:  div_next = DIV_DONE;
      DIV_DONE: div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
  end

  assign divide_busy = (div_state != DIV_IDLE);
  assign divide_done = (div_state == DIV_DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_dq         <= '0;
      div_rem        <= '0;
      div_dvs        <= '0;
      div_neg        <= 1'b0;
      div_sa         <= 1'b0;
      div_cnt        <= '0;
      divide_result  <= '0;
      divide_by_zero <= 1'b0;
    end else if (div_state == DIV_IDLE && divide_start) begin
      div_dq         <= {mag(divide_a), {FRAC_BITS{1'b0}}};
      div_rem        <= '0;
      div_dvs        <= mag(divide_b);
      div_neg        <= divide_a[W-1] ^ divide_b[W-1];
      div_sa         <= divide_a[W-1];
      div_cnt        <= CW'(DW - 1);
      divide_by_zero <= (divide_b == '0);
    end else if (div_state == DIV_RUN) begin
      div_rem <= div_ge ? div_diff : div_sh[W-1:0];
      div_dq  <= {div_dq[DW-2:0], div_ge};
      div_cnt <= div_cnt - CW'(1);
    end else if (div_state == DIV_FIX) begin
      if (divide_by_zero) divide_result <= div_sa ? SMIN[W-1:0] : SMAX[W-1:0];
      else                divide_result <= sat(div_neg ? -div_qx : div_qx);
    end
  end

endmodule

// File: tb/tb_arith_responder.sv
// Self-checking bench for arith_responder: directed cases plus randomized
// traffic compared against a plain-integer fixed-point reference model.
module tb_arith_responder;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0][31:0]  add_a = '0, add_b = '0, add_result;
  logic [1:0]        add_start = '0, add_done;
  logic [31:0]       mult_a = '0, mult_b = '0, mult_result;
  logic              mult_start = 1'b0, mult_done;
  logic [31:0]       exponent_a = '0, exponent_b = '0, exponent_result;
  logic              exponent_start = 1'b0, exponent_done, exponent_busy;
  logic [31:0]       divide_a = '0, divide_b = '0, divide_result;
  logic              divide_start = 1'b0, divide_done, divide_busy, divide_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  arith_responder dut (
    .clock(clock), .reset(reset),
    .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_result(add_result), .add_done(add_done),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_result(mult_result), .mult_done(mult_done),
    .exponent_a(exponent_a), .exponent_b(exponent_b), .exponent_start(exponent_start),
    .exponent_result(exponent_result), .exponent_done(exponent_done), .exponent_busy(exponent_busy),
    .divide_a(divide_a), .divide_b(divide_b), .divide_start(divide_start),
    .divide_result(divide_result), .divide_done(divide_done), .divide_busy(divide_busy),
    .divide_by_zero(divide_by_zero)
  );

  // reference model: real-number rules on 64-bit integers
  function automatic longint sv(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint clamp(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    return 32'(clamp(sv(a) + sv(b)));
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    return 32'(clamp((sv(a) * sv(b)) >>> 16));
  endfunction

  function automatic logic [31:0] m_exp(input logic [31:0] a, input logic [31:0] b);
    longint acc, base;
    acc  = 65536;
    base = sv(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = clamp((acc * base) >>> 16);
      base = clamp((base * base) >>> 16);
    end
    return 32'(acc);
  endfunction

  function automatic logic [31:0] m_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return (sv(a) >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return 32'(clamp((sv(a) * 65536) / sv(b)));
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r;
      1:       return {{12{r[19]}}, r[19:0]};
      default: return {{8{r[23]}}, r[23:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    add_start = 2'b11; mult_start = 1'b1; exponent_start = 1'b1; divide_start = 1'b1;
    tick(); tick();
    n_tests++;
    if ({add_done, add_result} !== '0) begin
      n_fail++; $display("FAIL reset_add: got done=%b res=%h, want 0", add_done, add_result);
    end
    n_tests++;
    if ({mult_done, mult_result} !== '0) begin
      n_fail++; $display("FAIL reset_mult: got done=%b res=%h, want 0", mult_done, mult_result);
    end
    n_tests++;
    if ({exponent_done, exponent_busy, exponent_result} !== '0) begin
      n_fail++; $display("FAIL reset_exp: got done=%b busy=%b res=%h, want 0", exponent_done, exponent_busy, exponent_result);
    end
    n_tests++;
    if ({divide_done, divide_busy, divide_by_zero, divide_result} !== '0) begin
      n_fail++; $display("FAIL reset_div: got done=%b busy=%b dz=%b res=%h, want 0", divide_done, divide_busy, divide_by_zero, divide_result);
    end
    add_start = '0; mult_start = 1'b0; exponent_start = 1'b0; divide_start = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic [1:0][31:0] held;
    logic [1:0]       st;
    add_a[0] = 32'h0001_8000; add_b[0] = 32'h0002_0000;
    add_a[1] = 32'h7FFF_0000; add_b[1] = 32'h0002_0000;
    add_start = 2'b11;
    tick();
    add_start = 2'b00;
    n_tests++;
    if (add_done !== 2'b11 || add_result[0] !== 32'h0003_8000 || add_result[1] !== 32'h7FFF_FFFF) begin
      n_fail++; $display("FAIL add_directed: got done=%b r0=%h r1=%h, want 11 00038000 7fffffff", add_done, add_result[0], add_result[1]);
    end
    held = add_result;
    for (int c = 0; c < 25; c++) begin
      st = (c == 24) ? 2'b00 : 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        add_a[i] = rnd_val(); add_b[i] = rnd_val();
        if (st[i]) held[i] = m_add(add_a[i], add_b[i]);
      end
      add_start = st;
      tick();
      n_tests++;
      if (add_done !== st || add_result !== held) begin
        n_fail++; $display("FAIL add_random c=%0d: got done=%b res=%h, want done=%b res=%h", c, add_done, add_result, st, held);
      end
    end
    add_start = 2'b00;
  endtask

  task automatic test_mult();
    localparam int N = 24;
    bit          hv[N+2];
    logic [31:0] hr[N+2];
    logic [31:0] held;
    mult_a = 32'h0001_8000; mult_b = 32'h0002_0000; mult_start = 1'b1;
    tick();
    mult_a = 32'hFFFE_8000;
    n_tests++;
    if (mult_done !== 1'b0) begin n_fail++; $display("FAIL mult_lat1: got done=%b, want 0", mult_done); end
    tick();
    mult_start = 1'b0;
    n_tests++;
    if (mult_done !== 1'b1 || mult_result !== 32'h0003_0000) begin
      n_fail++; $display("FAIL mult_first: got done=%b res=%h, want 1 00030000", mult_done, mult_result);
    end
    tick();
    n_tests++;
    if (mult_done !== 1'b1 || mult_result !== 32'hFFFD_0000) begin
      n_fail++; $display("FAIL mult_second: got done=%b res=%h, want 1 fffd0000", mult_done, mult_result);
    end
    tick();
    n_tests++;
    if (mult_done !== 1'b0 || mult_result !== 32'hFFFD_0000) begin
      n_fail++; $display("FAIL mult_hold: got done=%b res=%h, want 0 fffd0000", mult_done, mult_result);
    end
    held = 32'hFFFD_0000;
    for (int c = 0; c < N + 2; c++) begin
      if (c < N) begin
        mult_a = rnd_val(); mult_b = rnd_val();
        mult_start = ($urandom_range(0, 3) != 0);
        hv[c] = mult_start; hr[c] = m_mul(mult_a, mult_b);
      end else begin
        mult_start = 1'b0; hv[c] = 1'b0; hr[c] = '0;
      end
      tick();
      if (c >= 1) begin
        if (hv[c-1]) held = hr[c-1];
        n_tests++;
        if (mult_done !== hv[c-1] || mult_result !== held) begin
          n_fail++; $display("FAIL mult_random c=%0d: got done=%b res=%h, want done=%b res=%h", c, mult_done, mult_result, hv[c-1], held);
        end
      end
    end
    mult_start = 1'b0;
  endtask

  task automatic run_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    int lat;
    bit seen;
    for (int i = 0; i < 30 && exponent_busy; i++) tick();
    exponent_a = a; exponent_b = b; exponent_start = 1'b1;
    tick();
    exponent_start = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exponent_done === 1'b1) begin seen = 1'b1; break; end
      tick(); lat++;
    end
    n_tests++;
    if (!seen || lat != 9 || exponent_result !== want) begin
      n_fail++; $display("FAIL exp a=%h b=%h: got seen=%0d lat=%0d res=%h, want lat=9 res=%h", a, b, seen, lat, exponent_result, want);
    end
    tick();
    n_tests++;
    if (exponent_done !== 1'b0 || exponent_busy !== 1'b0 || exponent_result !== want) begin
      n_fail++; $display("FAIL exp_after: got done=%b busy=%b res=%h, want 0 0 %h", exponent_done, exponent_busy, exponent_result, want);
    end
  endtask

  task automatic test_exponent();
    logic [31:0] a, b, r;
    exponent_a = 32'h0001_8000; exponent_b = 32'd3; exponent_start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      exponent_start = 1'b0;
      if (c == 1) begin
        n_tests++;
        if (exponent_busy !== 1'b1) begin n_fail++; $display("FAIL exp_busy: got %b, want 1", exponent_busy); end
      end
      n_tests++;
      if (exponent_done !== (c == 9)) begin
        n_fail++; $display("FAIL exp_done_cycle c=%0d: got %b, want %b", c, exponent_done, (c == 9));
      end
      if (c == 9) begin
        n_tests++;
        if (exponent_result !== 32'h0003_6000) begin
          n_fail++; $display("FAIL exp_directed: got %h, want 00036000", exponent_result);
        end
      end
      if (c == 4) begin
        exponent_a = 32'h0002_0000; exponent_b = 32'd5; exponent_start = 1'b1;
      end
    end
    n_tests++;
    if (exponent_busy !== 1'b0 || exponent_result !== 32'h0003_6000) begin
      n_fail++; $display("FAIL exp_ignored: got busy=%b res=%h, want 0 00036000", exponent_busy, exponent_result);
    end
    run_exp(32'h0005_4321, 32'hABCD_EF00, 32'h0001_0000);
    for (int k = 0; k < 6; k++) begin
      r = $urandom;
      a = {{14{r[17]}}, r[17:0]};
      b = $urandom;
      run_exp(a, b, m_exp(a, b));
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want, input int want_lat);
    int lat;
    bit seen;
    for (int i = 0; i < 80 && divide_busy; i++) tick();
    divide_a = a; divide_b = b; divide_start = 1'b1;
    tick();
    divide_start = 1'b0;
    n_tests++;
    if (divide_busy !== 1'b1 || divide_by_zero !== (b == 32'd0)) begin
      n_fail++; $display("FAIL div_start a=%h b=%h: got busy=%b dz=%b, want 1 %b", a, b, divide_busy, divide_by_zero, (b == 32'd0));
    end
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (divide_done === 1'b1) begin seen = 1'b1; break; end
      tick(); lat++;
    end
    n_tests++;
    if (!seen || lat != want_lat || divide_result !== want || divide_by_zero !== (b == 32'd0)) begin
      n_fail++; $display("FAIL div a=%h b=%h: got seen=%0d lat=%0d res=%h dz=%b, want lat=%0d res=%h", a, b, seen, lat, divide_result, divide_by_zero, want_lat, want);
    end
    tick();
    n_tests++;
    if (divide_done !== 1'b0 || divide_busy !== 1'b0 || divide_result !== want) begin
      n_fail++; $display("FAIL div_after: got done=%b busy=%b res=%h, want 0 0 %h", divide_done, divide_busy, divide_result, want);
    end
  endtask

  task automatic test_divide();
    logic [31:0] a, b;
    run_div(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 50);
    run_div(32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 50);
    run_div(32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 2);
    run_div(32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 2);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 50);
    for (int k = 0; k < 6; k++) begin
      a = rnd_val();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : rnd_val();
      run_div(a, b, m_div(a, b), (b == 32'd0) ? 2 : 50);
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    divide_a = 32'h0003_0000; divide_b = 32'h0002_0000; divide_start = 1'b1;
    tick();
    divide_start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_tests++;
    if (divide_busy !== 1'b0 || divide_done !== 1'b0 || divide_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b done=%b res=%h, want 0 0 0", divide_busy, divide_done, divide_result);
    end
    saw = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (divide_done === 1'b1) saw = 1'b1;
    end
    n_tests++;
    if (saw) begin n_fail++; $display("FAIL reset_mid_no_done: got done after reset, want none"); end
    run_div(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 50);
  endtask

  task automatic test_concurrent();
    logic [31:0] ea, em, ee, ed, r;
    int la, lm, le, ld;
    logic [31:0] va, vm, ve, vd;
    for (int i = 0; i < 80 && (divide_busy || exponent_busy); i++) tick();
    add_a[0] = rnd_val(); add_b[0] = rnd_val(); add_start = 2'b01;
    mult_a = rnd_val(); mult_b = rnd_val(); mult_start = 1'b1;
    r = $urandom;
    exponent_a = {{14{r[17]}}, r[17:0]}; exponent_b = $urandom; exponent_start = 1'b1;
    divide_a = rnd_val(); divide_b = rnd_val() | 32'h100; divide_start = 1'b1;
    ea = m_add(add_a[0], add_b[0]); em = m_mul(mult_a, mult_b);
    ee = m_exp(exponent_a, exponent_b); ed = m_div(divide_a, divide_b);
    la = -1; lm = -1; le = -1; ld = -1;
    va = '0; vm = '0; ve = '0; vd = '0;
    for (int c = 1; c <= 56; c++) begin
      tick();
      add_start = 2'b00; mult_start = 1'b0; exponent_start = 1'b0; divide_start = 1'b0;
      if (add_done[0] && la < 0) begin la = c; va = add_result[0]; end
      if (mult_done && lm < 0) begin lm = c; vm = mult_result; end
      if (exponent_done && le < 0) begin le = c; ve = exponent_result; end
      if (divide_done && ld < 0) begin ld = c; vd = divide_result; end
    end
    n_tests++;
    if (la != 1 || va !== ea) begin n_fail++; $display("FAIL conc_add: got lat=%0d res=%h, want 1 %h", la, va, ea); end
    n_tests++;
    if (lm != 2 || vm !== em) begin n_fail++; $display("FAIL conc_mult: got lat=%0d res=%h, want 2 %h", lm, vm, em); end
    n_tests++;
    if (le != 9 || ve !== ee) begin n_fail++; $display("FAIL conc_exp: got lat=%0d res=%h, want 9 %h", le, ve, ee); end
    n_tests++;
    if (ld != 50 || vd !== ed) begin n_fail++; $display("FAIL conc_div: got lat=%0d res=%h, want 50 %h", ld, vd, ed); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_exponent();
    test_divide();
    test_reset_mid();
    test_concurrent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
